alu_issue_stage: RTL and testbench

Registered issue stage that sits directly in front of the ALU: accepts decoded instruction fields and operands from the ID stage over a valid/ready handshake, and translates ALUOp/funct3/funct7 into the 4-bit ALU `Operation` code. It selects `SrcB` between register and immediate, then presents a registered `{SrcA, SrcB, Operation}` bundle to EX. A two-entry skid buffer gives full throughput with a registered `InReady`. A flush input supports branch redirect.

---
 rtl/alu_issue_stage.sv | 192 +++++++++++++++++++
 tb/tb_alu_issue_stage.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_stage.sv
// Registered ALU issue stage: decodes ALUOp/Funct3/Funct7 into an ALU Operation code and buffers
// {SrcA, SrcB, Operation} behind a two-entry skid buffer. Optional macro: ALU_ILLEGAL_TRAP_EN.
module alu_issue_stage #(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     InValid,
  output logic                     InReady,
  input  logic [1:0]               ALUOp,
  input  logic [2:0]               Funct3,
  input  logic [6:0]               Funct7,
  input  logic                     ALUSrc,
  input  logic [DATA_WIDTH-1:0]    RD1,
  input  logic [DATA_WIDTH-1:0]    RD2,
  input  logic [DATA_WIDTH-1:0]    Imm,
  input  logic                     Flush,
  output logic                     OutValid,
  input  logic                     OutReady,
  output logic [DATA_WIDTH-1:0]    SrcA,
  output logic [DATA_WIDTH-1:0]    SrcB,
  output logic [OPCODE_LENGTH-1:0] Operation,
  output logic                     IllegalOp
);

  localparam logic [OPCODE_LENGTH-1:0] OP_AND = OPCODE_LENGTH'(4'b0000);
  localparam logic [OPCODE_LENGTH-1:0] OP_OR  = OPCODE_LENGTH'(4'b0001);
  localparam logic [OPCODE_LENGTH-1:0] OP_ADD = OPCODE_LENGTH'(4'b0010);
  localparam logic [OPCODE_LENGTH-1:0] OP_XOR = OPCODE_LENGTH'(4'b0011);
  localparam logic [OPCODE_LENGTH-1:0] OP_EQ  = OPCODE_LENGTH'(4'b1000);
  localparam logic [OPCODE_LENGTH-1:0] OP_ILL = '1;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    FULL  = 2'b10
  } state_t;

  typedef struct packed {
    logic [DATA_WIDTH-1:0]    srca;
    logic [DATA_WIDTH-1:0]    srcb;
    logic [OPCODE_LENGTH-1:0] op;
  } bundle_t;

  state_t  state;
  logic    in_ready_q;
  logic    out_valid_q;
  bundle_t out_q;
  bundle_t skid_q;
  bundle_t in_bundle;

  logic [OPCODE_LENGTH-1:0] arith_op;
  logic                     arith_ok;
  logic [OPCODE_LENGTH-1:0] dec_op;
  logic                     dec_illegal;
  logic                     accept;
  logic                     drain;
  logic                     take;

  // The ADD/AND/OR/XOR Funct3 map is shared by R-type and I-type ALU ops.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    arith_op = OP_ILL;
    arith_ok = 1'b0;
    case (Funct3)
      3'b000:  begin arith_op = OP_ADD; arith_ok = 1'b1; end
      3'b111:  begin arith_op = OP_AND; arith_ok = 1'b1; end
      3'b110:  begin arith_op = OP_OR;  arith_ok = 1'b1; end
      3'b100:  begin arith_op = OP_XOR; arith_ok = 1'b1; end
      default: begin arith_op = OP_ILL; arith_ok = 1'b0; end
    endcase
  end

  always_comb begin
    dec_op      = OP_ILL;
    dec_illegal = 1'b1;
    case (ALUOp)
      2'b00: begin
        dec_op      = OP_ADD;
        dec_illegal = 1'b0;
      end
      2'b01: begin
        if (Funct3 == 3'b000) begin
          dec_op      = OP_EQ;
          dec_illegal = 1'b0;
        end
      end
      2'b10: begin
        if (Funct7 == 7'b0000000 && arith_ok) begin
          dec_op      = arith_op;
          dec_illegal = 1'b0;
        end
      end
      default: begin
        if (arith_ok) begin
          dec_op      = arith_op;
          dec_illegal = 1'b0;
        end
      end
    endcase
  end

  always_comb begin
    in_bundle      = '0;
    in_bundle.srca = RD1;
    in_bundle.srcb = ALUSrc ? Imm : RD2;
    in_bundle.op   = dec_op;
  end

  assign accept = InValid & in_ready_q;
  assign drain  = out_valid_q & OutReady;

`ifdef ALU_ILLEGAL_TRAP_EN
  logic illegal_q;

  // Illegal bundles are swallowed: they leave the buffer occupancy untouched.
  assign take = accept & ~dec_illegal;

  always_ff @(posedge clk) begin
    if (reset) illegal_q <= 1'b0;
    else       illegal_q <= accept & dec_illegal & ~Flush;
  end

  assign IllegalOp = illegal_q;
`else
  assign take      = accept;
  assign IllegalOp = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= EMPTY;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_q       <= '0;
    end else if (Flush) begin
      state       <= EMPTY;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state)
        EMPTY: begin
          if (take) begin
            out_q       <= in_bundle;
            out_valid_q <= 1'b1;
            state       <= ONE;
          end
        end
        ONE: begin
          case ({take, drain})
            2'b10: begin
              state      <= FULL;
              in_ready_q <= 1'b0;
            end
            2'b01: begin
              out_valid_q <= 1'b0;
              state       <= EMPTY;
            end
            2'b11:   out_q <= in_bundle;
            default: ;
          endcase
        end
        FULL: begin
          if (drain) begin
            out_q      <= skid_q;
            state      <= ONE;
            in_ready_q <= 1'b1;
          end
        end
        default: begin
          state       <= EMPTY;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  // NOTE: the skid register is pure datapath; occupancy is tracked by state, so it needs no reset.
  always_ff @(posedge clk) begin
    if (!reset && !Flush && state == ONE && take && !drain) skid_q <= in_bundle;
  end

  assign InReady   = in_ready_q;
  assign OutValid  = out_valid_q;
  assign SrcA      = out_q.srca;
  assign SrcB      = out_q.srcb;
  assign Operation = out_q.op;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed self-checking bench for alu_issue_stage; follows ALU_ILLEGAL_TRAP_EN if defined.
module tb_alu_issue_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  alu_op;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic        alu_src;
  logic [31:0] rd1, rd2, imm;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] src_a, src_b;
  logic [3:0]  operation;
  logic        illegal_op;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_issue_stage #(.DATA_WIDTH(32), .OPCODE_LENGTH(4)) dut (
    .clk(clk), .reset(reset), .InValid(in_valid), .InReady(in_ready),
    .ALUOp(alu_op), .Funct3(funct3), .Funct7(funct7), .ALUSrc(alu_src),
    .RD1(rd1), .RD2(rd2), .Imm(imm), .Flush(flush),
    .OutValid(out_valid), .OutReady(out_ready),
    .SrcA(src_a), .SrcB(src_b), .Operation(operation), .IllegalOp(illegal_op)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [1:0] op, input logic [2:0] f3, input logic [6:0] f7,
                       input logic src, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] i);
    in_valid = 1'b1; alu_op = op; funct3 = f3; funct7 = f7;
    alu_src = src; rd1 = a; rd2 = b; imm = i;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
    alu_op = 2'b00; funct3 = 3'b000; funct7 = 7'd0; alu_src = 1'b0;
    rd1 = '0; rd2 = '0; imm = '0;
    tick();
    tick();
    reset = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_outvalid got %b want 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_inready got %b want 1", in_ready); end
    checks++; if (operation !== 4'b0000 || src_a !== 32'd0 || src_b !== 32'd0)
      begin errors++; $display("FAIL reset_data got op=%b a=%h b=%h want 0", operation, src_a, src_b); end
    checks++; if (illegal_op !== 1'b0) begin errors++; $display("FAIL reset_illegal got %b want 0", illegal_op); end
  endtask

  task automatic test_rtype();
    out_ready = 1'b1;
    offer(2'b10, 3'b000, 7'd0, 1'b0, 32'd5, 32'd7, 32'd99);
    tick();
    checks++; if (out_valid !== 1'b1 || src_a !== 32'd5 || src_b !== 32'd7 || operation !== 4'b0010)
      begin errors++; $display("FAIL add got v=%b a=%0d b=%0d op=%b want 1 5 7 0010", out_valid, src_a, src_b, operation); end
    offer(2'b10, 3'b110, 7'd0, 1'b0, 32'hA, 32'hB, 32'h0);
    tick();
    checks++; if (out_valid !== 1'b1 || operation !== 4'b0001 || src_b !== 32'hB)
      begin errors++; $display("FAIL or got v=%b op=%b b=%h want 1 0001 b", out_valid, operation, src_b); end
    offer(2'b00, 3'b101, 7'h7F, 1'b1, 32'h100, 32'h1, 32'h40);
    tick();
    checks++; if (operation !== 4'b0010 || src_b !== 32'h40 || src_a !== 32'h100)
      begin errors++; $display("FAIL mem_add got op=%b a=%h b=%h want 0010 100 40", operation, src_a, src_b); end
    in_valid = 1'b0;
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rtype_drain got %b want 0", out_valid); end
  endtask

  task automatic test_itype_branch();
    out_ready = 1'b1;
    offer(2'b11, 3'b100, 7'b0100000, 1'b1, 32'h1, 32'h12, 32'hFF);
    tick();
    checks++; if (out_valid !== 1'b1 || src_b !== 32'hFF || operation !== 4'b0011)
      begin errors++; $display("FAIL xori got v=%b b=%h op=%b want 1 ff 0011", out_valid, src_b, operation); end
    offer(2'b01, 3'b000, 7'd0, 1'b0, 32'h20, 32'h34, 32'hFF);
    tick();
    checks++; if (out_valid !== 1'b1 || src_b !== 32'h34 || operation !== 4'b1000)
      begin errors++; $display("FAIL beq got v=%b b=%h op=%b want 1 34 1000", out_valid, src_b, operation); end
    offer(2'b11, 3'b111, 7'd0, 1'b1, 32'h3, 32'h0, 32'h0F);
    tick();
    checks++; if (operation !== 4'b0000 || src_b !== 32'h0F)
      begin errors++; $display("FAIL andi got op=%b b=%h want 0000 f", operation, src_b); end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    offer(2'b10, 3'b000, 7'd0, 1'b0, 32'd1, 32'd0, 32'd0);
    tick();
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b1 || src_a !== 32'd1)
      begin errors++; $display("FAIL bp_first got rdy=%b v=%b a=%0d want 1 1 1", in_ready, out_valid, src_a); end
    offer(2'b10, 3'b000, 7'd0, 1'b0, 32'd2, 32'd0, 32'd0);
    tick();
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_full_ready got %b want 0", in_ready); end
    offer(2'b10, 3'b000, 7'd0, 1'b0, 32'd3, 32'd0, 32'd0);
    tick();
    checks++; if (in_ready !== 1'b0 || out_valid !== 1'b1 || src_a !== 32'd1)
      begin errors++; $display("FAIL bp_hold got rdy=%b v=%b a=%0d want 0 1 1", in_ready, out_valid, src_a); end
    out_ready = 1'b1;
    tick();
    checks++; if (src_a !== 32'd2 || in_ready !== 1'b1 || out_valid !== 1'b1)
      begin errors++; $display("FAIL bp_out2 got a=%0d rdy=%b v=%b want 2 1 1", src_a, in_ready, out_valid); end
    tick();
    checks++; if (src_a !== 32'd3 || out_valid !== 1'b1)
      begin errors++; $display("FAIL bp_out3 got a=%0d v=%b want 3 1", src_a, out_valid); end
    offer(2'b10, 3'b000, 7'd0, 1'b0, 32'd4, 32'd0, 32'd0);
    tick();
    checks++; if (src_a !== 32'd4 || out_valid !== 1'b1)
      begin errors++; $display("FAIL bp_out4 got a=%0d v=%b want 4 1", src_a, out_valid); end
    in_valid = 1'b0;
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_empty got %b want 0", out_valid); end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    offer(2'b00, 3'b000, 7'd0, 1'b0, 32'h11, 32'd0, 32'd0);
    tick();
    offer(2'b00, 3'b000, 7'd0, 1'b0, 32'h22, 32'd0, 32'd0);
    tick();
    offer(2'b00, 3'b000, 7'd0, 1'b0, 32'h99, 32'd0, 32'd0);
    flush = 1'b1;
    tick();
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1)
      begin errors++; $display("FAIL flush_full got v=%b rdy=%b want 0 1", out_valid, in_ready); end
    offer(2'b00, 3'b000, 7'd0, 1'b0, 32'h33, 32'd0, 32'd0);
    flush = 1'b0;
    tick();
    offer(2'b00, 3'b000, 7'd0, 1'b0, 32'h77, 32'd0, 32'd0);
    flush = 1'b1;
    tick();
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1)
      begin errors++; $display("FAIL flush_accept got v=%b rdy=%b want 0 1", out_valid, in_ready); end
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    tick();
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_leak got v=%b a=%h want 0", out_valid, src_a); end
  endtask

  task automatic test_illegal();
    out_ready = 1'b1;
    offer(2'b10, 3'b000, 7'b0100000, 1'b0, 32'd9, 32'd4, 32'd0);
    tick();
    in_valid = 1'b0;
`ifdef ALU_ILLEGAL_TRAP_EN
    checks++; if (illegal_op !== 1'b1 || out_valid !== 1'b0)
      begin errors++; $display("FAIL sub_trap got ill=%b v=%b want 1 0", illegal_op, out_valid); end
    tick();
    checks++; if (illegal_op !== 1'b0 || out_valid !== 1'b0)
      begin errors++; $display("FAIL sub_trap_pulse got ill=%b v=%b want 0 0", illegal_op, out_valid); end
`else
    checks++; if (out_valid !== 1'b1 || operation !== 4'b1111 || illegal_op !== 1'b0)
      begin errors++; $display("FAIL sub_fwd got v=%b op=%b ill=%b want 1 1111 0", out_valid, operation, illegal_op); end
    offer(2'b01, 3'b001, 7'd0, 1'b0, 32'd1, 32'd2, 32'd0);
    tick();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || operation !== 4'b1111)
      begin errors++; $display("FAIL bne_fwd got v=%b op=%b want 1 1111", out_valid, operation); end
    tick();
`endif
  endtask

  task automatic test_reset_full();
    out_ready = 1'b0;
    offer(2'b11, 3'b110, 7'd0, 1'b1, 32'h5, 32'h6, 32'h7);
    tick();
    tick();
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_full_pre got rdy=%b want 0", in_ready); end
    reset = 1'b1;
    tick();
    reset = 1'b0; in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || src_a !== 32'd0 || src_b !== 32'd0 ||
                  operation !== 4'b0000 || illegal_op !== 1'b0)
      begin errors++; $display("FAIL rst_full got v=%b rdy=%b a=%h b=%h op=%b ill=%b want 0 1 0 0 0000 0",
                               out_valid, in_ready, src_a, src_b, operation, illegal_op); end
    out_ready = 1'b1;
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_full_leak got %b want 0", out_valid); end
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_itype_branch();
    test_backpressure();
    test_flush();
    test_illegal();
    test_reset_full();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
